sys_rst_seq: RTL and testbench
==============================

// Module: sys_rst_seq
// PURPOSE
// Always-on reset sequencer directly upstream of the system clock/reset generator; drives its global
// reset input (rstn_glob) and a cluster reset request. Stretches POR, software reset and external
// reset requests to a programmable hold time. Records the reset cause in a small APB register file.
// Clocked by the free-running ref clock; it is never reset by the resets it generates.
// PARAMETERS
// HOLD_RST     16  reset value of HOLD_CYC: cycles rstn_glob_o stays low after rst_ni release
// CNT_W        16  width of HOLD_CYC register and hold counter
// SYNC_STAGES  2   synchroniser depth for ext_rst_req_i (>=2)
// PORTS
// clk_i          in   1      ref clock, single clock domain
// rst_ni         in   1      asynchronous, active-low power-on reset
// ext_rst_req_i  in   1      asynchronous external reset request, active high, level
// psel_i         in   1      APB select
// penable_i      in   1      APB enable
// pwrite_i       in   1      APB write
// paddr_i        in   12     APB address (byte)
// pwdata_i       in   32     APB write data
// prdata_o       out  32     APB read data
// pready_o       out  1      APB ready, tied 1
// pslverr_o      out  1      APB error
// rstn_glob_o    out  1      global reset to clock/reset generator, active low, flop-driven
// rstn_cluster_o out  1      cluster reset request, active low, flop-driven
// BEHAVIOUR
// - rst_ni low: state=HOLD, cnt=HOLD_RST-1, rstn_glob_o=0, rstn_cluster_o=0, CL_HOLD=0,
//   CAUSE=3'b001, HOLD_CYC=HOLD_RST, sync flops=0. rst_ni low mid-operation -> these values immediately.
// - FSM {HOLD, RUN}. HOLD: rstn_glob_o=0. If cnt!=0, cnt decrements. If cnt==0, go to RUN.
//   RUN: rstn_glob_o=1. rstn_glob_o is a dedicated flop equal to (state==RUN), so no glitches.
// - After rst_ni rises, rstn_glob_o rises on the HOLD_RST-th rising clk edge.
// - Trigger = SW_RST write OR ext_sync==1. ext_sync is the SYNC_STAGES-flop synchronised ext_rst_req_i.
// - Trigger in RUN: next state HOLD, cnt = N-1 with N = (HOLD_CYC==0 ? 1 : HOLD_CYC).
//   rstn_glob_o falls on that same edge.
// - Trigger in HOLD: cnt reloads to N-1. A held ext request therefore keeps reset asserted.
//   Release comes N cycles after ext_sync falls.
// - Every entry into HOLD (including POR) clears CL_HOLD.
// - rstn_cluster_o is registered: next = rstn_glob_o & ~CL_HOLD (one-cycle lag).
// - APB: zero-wait; pready_o=1. Write takes effect on the edge where psel_i&penable_i&pwrite_i.
//   prdata_o is combinational from registers when psel_i, else 0.
// - pslverr_o = psel_i&penable_i & unmapped paddr_i[11:0]. On error: write ignored, prdata_o=0.
// - 0x000 CTRL: bit0 SW_RST (write-1 pulses a trigger, reads 0); bit1 CL_HOLD (RW). Other bits RAZ/WI.
// - 0x004 CAUSE: bit0 POR, bit1 SW, bit2 EXT; sticky, W1C.
//   A cause is set on trigger entry/reload; the bit is set for a SW trigger and/or EXT trigger.
//   Simultaneous set and W1C on the same bit: set wins.
// - 0x008 HOLD_CYC[CNT_W-1:0]: RW, upper bits RAZ. A write during HOLD does not alter the running cnt;
//   it is used at the next load.
// - CAUSE and HOLD_CYC are reset only by rst_ni, never by SW/EXT reset.
// TESTING
// 1. POR: rst_ni low 5 cyc, then high (HOLD_RST=16) -> rstn_glob_o low 16 edges, high on 16th;
//    rstn_cluster_o high 1 cyc later; read 0x004 = 0x1.
// 2. SW reset: write 0x008=4, then write 0x000=0x1 -> rstn_glob_o 0 on the write edge for 4 cyc;
//    0x004 = 0x3; write 0x004=0x7 -> reads 0x0.
// 3. EXT: ext_rst_req_i high 10 cyc -> rstn_glob_o low 2 cyc after rise; high 4 cyc after ext_sync
//    falls; 0x004 bit2=1.
// 4. Cluster: write 0x000=0x2 -> rstn_cluster_o 0 next cyc, rstn_glob_o stays 1; write 0x000=0x0 ->
//    1 next cyc; SW reset clears CL_HOLD.
// 5. Corners: HOLD_CYC=0 + SW_RST -> 1-cyc pulse; read 0x00C -> pslverr_o=1, prdata_o=0;
//    W1C 0x2 same cycle as SW_RST -> bit1 stays 1.
// 6. Reset mid-HOLD: rst_ni low at cnt=2 -> outputs/registers to reset values asynchronously;
//    full HOLD_RST sequence on release.

Source files
------------

// File: rtl/sys_rst_seq_if.sv
// APB slave bundle for the reset sequencer register file.
// Zero-wait-state APB; the master drives requests, the slave answers.
interface sys_rst_seq_if;
   logic        psel_i;
   logic        penable_i;
   logic        pwrite_i;
   logic [11:0] paddr_i;
   logic [31:0] pwdata_i;
   logic [31:0] prdata_o;
   logic        pready_o;
   logic        pslverr_o;

   modport master (
      output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
      input  prdata_o, pready_o, pslverr_o
   );

   modport slave (
      input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
      output prdata_o, pready_o, pslverr_o
   );
endinterface

// File: rtl/sys_rst_seq.sv
// Always-on reset sequencer: stretches POR/SW/EXT resets to a
// programmable hold time and records the reset cause over APB.
module sys_rst_seq #(
   parameter int HOLD_RST    = 16,
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         ext_rst_req_i,
   sys_rst_seq_if.slave apb,
   output logic         rstn_glob_o,
   output logic         rstn_cluster_o
);

   typedef enum logic {HOLD, RUN} state_t;

   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       hold_cyc;
   logic [CNT_W-1:0]       load_val;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   ext_sync;
   logic                   cl_hold;
   logic [2:0]             cause;
   logic [2:0]             cause_set;
   logic [2:0]             cause_clr;
   logic                   acc;
   logic                   wr;
   logic                   sel_ctrl;
   logic                   sel_cause;
   logic                   sel_hold;
   logic                   mapped;
   logic                   sw_trig;
   logic                   trig;
   logic [31:0]            rdata;
   logic                   unused_ok;

   assign ext_sync  = sync_q[SYNC_STAGES-1];
   assign acc       = apb.psel_i & apb.penable_i;
   assign sel_ctrl  = (apb.paddr_i == 12'h000);
   assign sel_cause = (apb.paddr_i == 12'h004);
   assign sel_hold  = (apb.paddr_i == 12'h008);
   assign mapped    = sel_ctrl | sel_cause | sel_hold;
   assign wr        = acc & apb.pwrite_i & mapped;
   assign sw_trig   = wr & sel_ctrl & apb.pwdata_i[0];
   assign trig      = sw_trig | ext_sync;
   assign load_val  = (hold_cyc == '0) ? '0 : hold_cyc - 1'b1;
   assign cause_set = {ext_sync, sw_trig, 1'b0};
   assign cause_clr = (wr & sel_cause) ? apb.pwdata_i[2:0] : 3'b000;
   assign unused_ok = ^apb.pwdata_i;

   assign apb.pready_o  = 1'b1;
   assign apb.pslverr_o = acc & ~mapped;
   assign apb.prdata_o  = rdata;

   // Register read mux; unmapped or idle bus reads zero.
   always_comb begin
      rdata = '0;
      if (apb.psel_i) begin
         unique case (1'b1)
            sel_ctrl:  rdata = {30'd0, cl_hold, 1'b0};
            sel_cause: rdata = {29'd0, cause};
            sel_hold:  rdata = 32'(hold_cyc);
            default:   rdata = '0;
         endcase
      end
   end

   // Synchroniser for the asynchronous external reset request.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ext_rst_req_i};
      end
   end

   // HOLD/RUN sequencer; rstn_glob_o is its own flop so it never glitches.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= HOLD;
         cnt         <= CNT_W'(HOLD_RST - 1);
         rstn_glob_o <= 1'b0;
      end else if (trig) begin
         state       <= HOLD;
         cnt         <= load_val;
         rstn_glob_o <= 1'b0;
      end else begin
         unique case (state)
            HOLD: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  state       <= RUN;
                  rstn_glob_o <= 1'b1;
               end
            end
            RUN: rstn_glob_o <= 1'b1;
            default: begin
               state       <= HOLD;
               rstn_glob_o <= 1'b0;
            end
         endcase
      end
   end

   // Software registers; a trigger drops CL_HOLD and wins over W1C.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cl_hold  <= 1'b0;
         cause    <= 3'b001;
         hold_cyc <= CNT_W'(HOLD_RST);
      end else begin
         if (trig) begin
            cl_hold <= 1'b0;
         end else if (wr & sel_ctrl) begin
            cl_hold <= apb.pwdata_i[1];
         end
         cause <= (cause & ~cause_clr) | cause_set;
         if (wr & sel_hold) begin
            hold_cyc <= apb.pwdata_i[CNT_W-1:0];
         end
      end
   end

   // Cluster reset follows the global reset one cycle later.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rstn_cluster_o <= 1'b0;
      end else begin
         rstn_cluster_o <= rstn_glob_o & ~cl_hold;
      end
   end

endmodule

// File: tb/tb_sys_rst_seq.sv
// Scoreboard bench for sys_rst_seq: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_sys_rst_seq;

   typedef struct {
      int   cyc;
      logic glob;
      logic clu;
   } pin_t;

   typedef struct {
      logic [11:0] addr;
      logic [31:0] data;
      logic        err;
   } rd_t;

   logic clk;
   logic rst_ni;
   logic ext_rst_req;
   logic rstn_glob;
   logic rstn_cluster;
   int   cyc;
   int   n_cmp;
   int   n_err;
   pin_t pin_q[$];
   rd_t  rd_q[$];
   pin_t mp;
   rd_t  mr;

   sys_rst_seq_if apb ();

   sys_rst_seq #(
      .HOLD_RST(16),
      .CNT_W(16),
      .SYNC_STAGES(2)
   ) dut (
      .clk_i(clk),
      .rst_ni(rst_ni),
      .ext_rst_req_i(ext_rst_req),
      .apb(apb),
      .rstn_glob_o(rstn_glob),
      .rstn_cluster_o(rstn_cluster)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare reads during access phase and pin states by cycle.
   always @(negedge clk) begin
      if (apb.psel_i && apb.penable_i && !apb.pwrite_i) begin
         n_cmp++;
         if (rd_q.size() == 0) begin
            n_err++;
            $display("FAIL rd_unexpected addr=%03h", apb.paddr_i);
         end else begin
            mr = rd_q.pop_front();
            if (apb.prdata_o !== mr.data || apb.pslverr_o !== mr.err ||
                apb.pready_o !== 1'b1 || apb.paddr_i !== mr.addr) begin
               n_err++;
               $display("FAIL rd_%03h: got data=%08h err=%0b rdy=%0b, want data=%08h err=%0b rdy=1",
                        mr.addr, apb.prdata_o, apb.pslverr_o, apb.pready_o,
                        mr.data, mr.err);
            end
         end
      end
      while (pin_q.size() > 0 && pin_q[0].cyc <= cyc) begin
         mp = pin_q.pop_front();
         n_cmp++;
         if (mp.cyc < cyc) begin
            n_err++;
            $display("FAIL pin_missed cyc=%0d now=%0d", mp.cyc, cyc);
         end else if (rstn_glob !== mp.glob || rstn_cluster !== mp.clu) begin
            n_err++;
            $display("FAIL pins_cyc%0d: got glob=%0b clu=%0b, want glob=%0b clu=%0b",
                     mp.cyc, rstn_glob, rstn_cluster, mp.glob, mp.clu);
         end
      end
   end

   task automatic pe(input int c, input logic g, input logic cl);
      pin_q.push_back('{cyc: c, glob: g, clu: cl});
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apb_write(input logic [11:0] a, input logic [31:0] d,
                            output int we);
      @(posedge clk);
      #1;
      apb.psel_i    = 1'b1;
      apb.penable_i = 1'b0;
      apb.pwrite_i  = 1'b1;
      apb.paddr_i   = a;
      apb.pwdata_i  = d;
      @(posedge clk);
      #1;
      apb.penable_i = 1'b1;
      @(posedge clk);
      #1;
      we            = cyc;
      apb.psel_i    = 1'b0;
      apb.penable_i = 1'b0;
      apb.pwrite_i  = 1'b0;
   endtask

   task automatic apb_read(input logic [11:0] a, input logic [31:0] d,
                           input logic e);
      @(posedge clk);
      #1;
      apb.psel_i    = 1'b1;
      apb.penable_i = 1'b0;
      apb.pwrite_i  = 1'b0;
      apb.paddr_i   = a;
      @(posedge clk);
      #1;
      apb.penable_i = 1'b1;
      rd_q.push_back('{addr: a, data: d, err: e});
      @(posedge clk);
      #1;
      apb.psel_i    = 1'b0;
      apb.penable_i = 1'b0;
   endtask

   initial begin
      int r;
      int w;
      int e;
      int c;
      int s;
      cyc           = 0;
      n_cmp         = 0;
      n_err         = 0;
      rst_ni        = 1'b0;
      ext_rst_req   = 1'b0;
      apb.psel_i    = 1'b0;
      apb.penable_i = 1'b0;
      apb.pwrite_i  = 1'b0;
      apb.paddr_i   = '0;
      apb.pwdata_i  = '0;

      // POR release: rise on the 16th edge, cluster one later
      repeat (5) @(posedge clk);
      #1;
      r = cyc;
      pe(r, 1'b0, 1'b0);
      rst_ni = 1'b1;
      pe(r + 15, 1'b0, 1'b0);
      pe(r + 16, 1'b1, 1'b0);
      pe(r + 17, 1'b1, 1'b1);
      wait_cyc(r + 18);
      apb_read(12'h004, 32'h1, 1'b0);
      apb_read(12'h008, 32'h10, 1'b0);

      // SW reset with HOLD_CYC=4
      apb_write(12'h008, 32'h4, w);
      apb_write(12'h000, 32'h1, w);
      pe(w, 1'b0, 1'b1);
      pe(w + 1, 1'b0, 1'b0);
      pe(w + 3, 1'b0, 1'b0);
      pe(w + 4, 1'b1, 1'b0);
      pe(w + 5, 1'b1, 1'b1);
      wait_cyc(w + 6);
      apb_read(12'h004, 32'h3, 1'b0);
      apb_write(12'h004, 32'h7, w);
      apb_read(12'h004, 32'h0, 1'b0);

      // EXT request held 10 cycles; W1C of EXT while it is setting
      @(posedge clk);
      #1;
      e = cyc;
      ext_rst_req = 1'b1;
      pe(e + 2, 1'b1, 1'b1);
      pe(e + 3, 1'b0, 1'b1);
      pe(e + 4, 1'b0, 1'b0);
      pe(e + 15, 1'b0, 1'b0);
      pe(e + 16, 1'b1, 1'b0);
      pe(e + 17, 1'b1, 1'b1);
      wait_cyc(e + 3);
      apb_write(12'h004, 32'h4, w);
      wait_cyc(e + 10);
      ext_rst_req = 1'b0;
      wait_cyc(e + 18);
      apb_read(12'h004, 32'h4, 1'b0);

      // Cluster hold on/off, then SW reset clears it
      apb_write(12'h000, 32'h2, c);
      pe(c, 1'b1, 1'b1);
      pe(c + 1, 1'b1, 1'b0);
      apb_read(12'h000, 32'h2, 1'b0);
      apb_write(12'h000, 32'h0, c);
      pe(c, 1'b1, 1'b0);
      pe(c + 1, 1'b1, 1'b1);
      apb_write(12'h000, 32'h2, c);
      pe(c + 1, 1'b1, 1'b0);
      apb_write(12'h000, 32'h1, s);
      pe(s, 1'b0, 1'b0);
      pe(s + 4, 1'b1, 1'b0);
      pe(s + 5, 1'b1, 1'b1);
      wait_cyc(s + 6);
      apb_read(12'h000, 32'h0, 1'b0);
      apb_read(12'h004, 32'h6, 1'b0);

      // HOLD_CYC=0 gives a one-cycle pulse; unmapped access errors
      apb_write(12'h008, 32'h0, w);
      apb_write(12'h000, 32'h1, s);
      pe(s, 1'b0, 1'b1);
      pe(s + 1, 1'b1, 1'b0);
      pe(s + 2, 1'b1, 1'b1);
      wait_cyc(s + 3);
      apb_read(12'h008, 32'h0, 1'b0);
      apb_read(12'h00C, 32'h0, 1'b1);
      apb_write(12'h008, 32'hABCD_0005, w);
      apb_read(12'h008, 32'h5, 1'b0);

      // POR asserted mid-HOLD at cnt==2
      apb_write(12'h000, 32'h1, s);
      wait_cyc(s + 2);
      rst_ni = 1'b0;
      pe(s + 2, 1'b0, 1'b0);
      apb_read(12'h004, 32'h1, 1'b0);
      apb_read(12'h008, 32'h10, 1'b0);
      apb_read(12'h000, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      r = cyc;
      pe(r, 1'b0, 1'b0);
      rst_ni = 1'b1;
      pe(r + 15, 1'b0, 1'b0);
      pe(r + 16, 1'b1, 1'b0);
      pe(r + 17, 1'b1, 1'b1);
      wait_cyc(r + 18);
      apb_read(12'h004, 32'h1, 1'b0);

      // POR in RUN drops both outputs before the next edge
      @(posedge clk);
      #1;
      rst_ni = 1'b0;
      pe(cyc, 1'b0, 1'b0);
      wait_cyc(cyc + 2);
      rst_ni = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      while (pin_q.size() > 0) begin
         mp = pin_q.pop_front();
         n_cmp++;
         n_err++;
         $display("FAIL pin_unchecked cyc=%0d", mp.cyc);
      end
      while (rd_q.size() > 0) begin
         mr = rd_q.pop_front();
         n_cmp++;
         n_err++;
         $display("FAIL rd_unchecked addr=%03h", mr.addr);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
